// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical pixel counters plus registered
// blank, sync, line/frame strobes and frame counter, all aligned to (DrawX, DrawY).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON  = 1'(SYNC_POL != 0);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       x_wrap_s;

  // Next position, then every flag decoded from that next position so the
  // registered flags describe the same pixel as the registered counters.
  always_comb begin
    x_wrap_s = (x_q == H_LAST);

    if (x_wrap_s) begin
      x_d = 10'd0;
    end else begin
      x_d = x_q + 10'd1;
    end

    if (!x_wrap_s) begin
      y_d = y_q;
    end else if (y_q == V_LAST) begin
      y_d = 10'd0;
    end else begin
      y_d = y_q + 10'd1;
    end

    if ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) begin
      hs_d = SYNC_ON;
    end else begin
      hs_d = ~SYNC_ON;
    end

    if ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) begin
      vs_d = SYNC_ON;
    end else begin
      vs_d = ~SYNC_ON;
    end

    blank_d       = (x_d < H_ACT) && (y_d < V_ACT);
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);

    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // State registers; reset parks at the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      blank_q       <= 1'b0;
      hs_q          <= ~SYNC_ON;
      vs_q          <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
